code_entry_ctrl: RTL and testbench
==================================

Name: code_entry_ctrl

Overview:
Keypad-side initiator for the combination lock. It collects BCD digits one key at a time and packs them into a code word. It presents the code to the lock checker over a valid/ready handshake, then consumes the pass/fail result. It owns the attempt counter and a timed lockout after repeated failures.

Parameters:
NUM_DIGITS, 4, digits per code; code width CW = 4*NUM_DIGITS
MAX_ATTEMPTS, 3, consecutive failed submissions before lockout
LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
key_valid  in  1  key event present
key_code  in  4  0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF illegal
key_ready  out  1  block accepts a key this cycle
code_out  out  CW  packed code, first digit in the MS nibble
code_valid  out  1  code_out offered to the lock
code_ready  in  1  lock accepts code_out
result_valid  in  1  lock verdict present
result_pass  in  1  1 = code matched
digit_count  out  $clog2(NUM_DIGITS+1)  digits buffered so far
attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining tries
unlocked  out  1  one-cycle pulse on a pass verdict
entry_error  out  1  one-cycle pulse on a rejected key
locked_out  out  1  level, high during lockout

Behaviour:
- Reset (reset==0 at the clock edge) overrides everything. It forces:
  - state ENTRY, buffer 0, digit_count 0, attempts_left MAX_ATTEMPTS
  - code_out 0, code_valid 0, unlocked 0, entry_error 0, locked_out 0
  - key_ready 1, starting the cycle after reset.
- Reset mid-handshake or mid-lockout drops code_valid and locked_out with no further effect.
- States: ENTRY, SEND, WAIT_RES, LOCKOUT. key_ready = (state==ENTRY), decoded from state.
- A key is accepted when key_valid && key_ready. Its effects are visible on the next cycle.
- ENTRY, digit 0-9:
  - If digit_count < NUM_DIGITS: buffer = {buffer[CW-5:0], key}, digit_count +1.
  - Otherwise: entry_error pulse, buffer unchanged.
- ENTRY, CLEAR: buffer and digit_count go to 0. No error.
- ENTRY, ENTER:
  - If digit_count == NUM_DIGITS: code_out <= buffer, buffer/count cleared, go to SEND. code_valid is high on the next cycle.
  - Otherwise: entry_error pulse, buffer/count cleared, stay in ENTRY.
- ENTRY, 0xC-0xF: entry_error pulse, no other change.
- SEND:
  - code_valid = 1; code_out is held stable until the handshake completes.
  - On code_valid && code_ready: go to WAIT_RES, code_valid drops on the next cycle.
  - No timeout; SEND waits indefinitely.
- WAIT_RES (result_valid is sampled only in this state; it is ignored in all other states, including the handshake cycle):
  - Pass: unlocked pulse, attempts_left <= MAX_ATTEMPTS, go to ENTRY.
  - Fail with attempts_left > 1: decrement, go to ENTRY.
  - Fail with attempts_left == 1: attempts_left <= 0, go to LOCKOUT, timer loaded with LOCKOUT_CYCLES-1.
- LOCKOUT:
  - locked_out = 1; keys are not accepted (key_ready = 0).
  - Timer decrements each cycle. On the cycle the timer is 0: attempts_left <= MAX_ATTEMPTS, go to ENTRY.
  - Total time in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- code_out retains its last submitted value outside SEND. It is not cleared on return to ENTRY.
- unlocked and entry_error are registered pulses, exactly one cycle wide. They cannot both be high in the same cycle.

Decomposition:
- Package comb_lock_pkg holds:
  - KEY_CLEAR = 4'hA, KEY_ENTER = 4'hB
  - state enum entry_state_t {ENTRY, SEND, WAIT_RES, LOCKOUT}
  - default NUM_DIGITS and MAX_ATTEMPTS constants shared with the lock checker
- One sub-module: lockout_timer. It is a loadable down-counter with ports clk, reset, load, load_val, and a done flag raised when the count is 0. It is parameterised on LOCKOUT_CYCLES width.

Test Plan:
- Keys 1,4,7,3,ENTER, code_ready held 1 -> code_out=16'h1473, code_valid high exactly 1 cycle. result_valid=1/pass=1 -> unlocked pulse, attempts_left=3.
- Keys 1,4,ENTER -> entry_error pulse, digit_count=0, code_valid stays 0. Keys 1,4,7,3,9 -> 5th digit gives entry_error, code_out after ENTER = 16'h1473.
- Keys 2,CLEAR,9,9,9,9,ENTER -> code_out=16'h9999. code_ready held 0 for 5 cycles -> code_valid and code_out stable, key_ready=0 throughout.
- Three fail verdicts, LOCKOUT_CYCLES=8 -> attempts_left 2,1,0, then locked_out high exactly 8 cycles, keys ignored. Afterwards key_ready=1, attempts_left=3.
- result_valid pulsed while in ENTRY and in SEND -> no change to attempts_left or state. Key 0xD -> entry_error only.
- reset=0 asserted during SEND and during LOCKOUT -> next cycle all outputs at reset values, key_ready=1, attempts_left=3.

Source files
------------

// File: rtl/comb_lock_pkg.sv
// comb_lock_pkg: key codes, FSM state type and default sizes shared by the lock blocks
package comb_lock_pkg;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int MAX_ATTEMPTS_DEF = 3;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  typedef enum logic [1:0] {ENTRY, SEND, WAIT_RES, LOCKOUT} entry_state_t;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter that parks at zero and flags done there
module lockout_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: keypad code collector with valid/ready submission, attempt counting and timed lockout
module code_entry_ctrl
  import comb_lock_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
  parameter int LOCKOUT_CYCLES = 1000,
  localparam int CW = 4 * NUM_DIGITS,
  localparam int DW = $clog2(NUM_DIGITS + 1),
  localparam int AW = $clog2(MAX_ATTEMPTS + 1),
  localparam int TW = LOCKOUT_CYCLES > 1 ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic          key_ready,
  output logic [CW-1:0] code_out,
  output logic          code_valid,
  input  logic          code_ready,
  input  logic          result_valid,
  input  logic          result_pass,
  output logic [DW-1:0] digit_count,
  output logic [AW-1:0] attempts_left,
  output logic          unlocked,
  output logic          entry_error,
  output logic          locked_out
);
  entry_state_t state_q, state_d;
  logic [CW-1:0] buf_q, buf_d, code_q, code_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] att_q, att_d;
  logic unl_q, unl_d, err_q, err_d, load, done;
  lockout_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(TW'(LOCKOUT_CYCLES - 1)),
    .done(done)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    code_d = code_q;
    att_d = att_q;
    unl_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    case (state_q)
      ENTRY: if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (cnt_q < DW'(NUM_DIGITS)) begin
            buf_d = CW'({buf_q, key_code});
            cnt_d = cnt_q + DW'(1);
          end else err_d = 1'b1;
        end else if (key_code == KEY_CLEAR || key_code == KEY_ENTER) begin
          buf_d = '0;
          cnt_d = '0;
          if (key_code == KEY_ENTER) begin
            if (cnt_q == DW'(NUM_DIGITS)) begin
              code_d = buf_q;
              state_d = SEND;
            end else err_d = 1'b1;
          end
        end else err_d = 1'b1;
      end
      SEND: if (code_ready) state_d = WAIT_RES;
      WAIT_RES: if (result_valid) begin
        if (result_pass) begin
          unl_d = 1'b1;
          att_d = AW'(MAX_ATTEMPTS);
          state_d = ENTRY;
        end else if (att_q > AW'(1)) begin
          att_d = att_q - AW'(1);
          state_d = ENTRY;
        end else begin
          att_d = '0;
          load = 1'b1;
          state_d = LOCKOUT;
        end
      end
      default: if (done) begin
        att_d = AW'(MAX_ATTEMPTS);
        state_d = ENTRY;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ENTRY;
      buf_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
      att_q <= AW'(MAX_ATTEMPTS);
      unl_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      att_q <= att_d;
      unl_q <= unl_d;
      err_q <= err_d;
    end
  end
  assign key_ready = state_q == ENTRY;
  assign code_valid = state_q == SEND;
  assign locked_out = state_q == LOCKOUT;
  assign code_out = code_q;
  assign digit_count = cnt_q;
  assign attempts_left = att_q;
  assign unlocked = unl_q;
  assign entry_error = err_q;
endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb_code_entry_ctrl: table, directed and random checks of code_entry_ctrl against a queue-based model
module tb_code_entry_ctrl;
  localparam int N = 4, MA = 3, L = 8;
  logic clk = 0, reset = 0, key_valid = 0, code_ready = 0, result_valid = 0, result_pass = 0;
  logic [3:0] key_code = 0;
  logic key_ready, code_valid, unlocked, entry_error, locked_out;
  logic [15:0] code_out;
  logic [2:0] digit_count;
  logic [1:0] attempts_left;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  code_entry_ctrl #(.NUM_DIGITS(N), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .result_valid(result_valid), .result_pass(result_pass), .digit_count(digit_count),
    .attempts_left(attempts_left), .unlocked(unlocked), .entry_error(entry_error), .locked_out(locked_out)
  );
  typedef enum {M_ENTRY, M_SEND, M_WAIT, M_LOCK} mph_t;
  mph_t mph = M_ENTRY;
  int digs[$];
  int m_att = MA, m_left = 0;
  logic [15:0] m_code = 0;
  bit m_unl = 0, m_err = 0;
  typedef struct {
    bit kv; logic [3:0] kc; bit cr, rv, rp;
    int dc; bit cv; logic [15:0] code; bit err, unl, kr; int att;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit kv, logic [3:0] kc, bit cr, rv, rp, int dc, bit cv,
                              logic [15:0] code, bit err, unl, kr, int att);
    vec_t v;
    v.kv = kv; v.kc = kc; v.cr = cr; v.rv = rv; v.rp = rp;
    v.dc = dc; v.cv = cv; v.code = code; v.err = err; v.unl = unl; v.kr = kr; v.att = att;
    return v;
  endfunction
  function void model(bit r, bit kv, logic [3:0] kc, bit cr, bit rv, bit rp);
    if (!r) begin
      mph = M_ENTRY; digs.delete(); m_att = MA; m_left = 0; m_code = 0; m_unl = 0; m_err = 0;
      return;
    end
    m_unl = 0;
    m_err = 0;
    case (mph)
      M_ENTRY: if (kv) begin
        if (kc < 10) begin
          if (digs.size() < N) digs.push_back(int'(kc)); else m_err = 1;
        end else if (kc == 4'hA) digs.delete();
        else if (kc == 4'hB) begin
          if (digs.size() == N) begin
            m_code = 0;
            foreach (digs[i]) m_code = m_code + 16'(digs[i] * (16 ** (N - 1 - i)));
            mph = M_SEND;
          end else m_err = 1;
          digs.delete();
        end else m_err = 1;
      end
      M_SEND: if (cr) mph = M_WAIT;
      M_WAIT: if (rv) begin
        if (rp) begin m_unl = 1; m_att = MA; mph = M_ENTRY; end
        else begin
          m_att--;
          mph = m_att == 0 ? M_LOCK : M_ENTRY;
          m_left = L;
        end
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_att = MA; mph = M_ENTRY; end
      end
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit kv, input logic [3:0] kc, input bit cr, input bit rv, input bit rp);
    reset = r; key_valid = kv; key_code = kc; code_ready = cr; result_valid = rv; result_pass = rp;
    @(posedge clk);
    model(r, kv, kc, cr, rv, rp);
    #1;
    chk("key_ready", key_ready, mph == M_ENTRY);
    chk("code_valid", code_valid, mph == M_SEND);
    chk("locked_out", locked_out, mph == M_LOCK);
    chk("digit_count", digit_count, digs.size());
    chk("attempts_left", attempts_left, m_att);
    chk("unlocked", unlocked, m_unl);
    chk("entry_error", entry_error, m_err);
    chk("code_out", code_out, m_code);
  endtask
  task automatic submit(input logic [15:0] c);
    for (int i = 0; i < 4; i++) cyc(1, 1, c[15 - 4 * i -: 4], 0, 0, 0);
    cyc(1, 1, 4'hB, 0, 0, 0);
  endtask
  task automatic fail_once();
    submit(16'h1234);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
  endtask
  initial begin
    int n;
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h4, 0, 0, 0, 2, 0, 16'h0000, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h7, 0, 0, 0, 3, 0, 16'h0000, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 4, 0, 16'h0000, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'hB, 1, 0, 0, 0, 1, 16'h1473, 0, 0, 0, 3));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 16'h1473, 0, 0, 0, 3));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 16'h1473, 0, 1, 1, 3));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h4, 0, 0, 0, 2, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'hB, 0, 0, 0, 0, 0, 16'h1473, 1, 0, 1, 3));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h4, 0, 0, 0, 2, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h7, 0, 0, 0, 3, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 4, 0, 16'h1473, 0, 0, 1, 3));
    tbl.push_back(mk(1, 4'h9, 0, 0, 0, 4, 0, 16'h1473, 1, 0, 1, 3));
    tbl.push_back(mk(1, 4'hB, 0, 0, 0, 0, 1, 16'h1473, 0, 0, 0, 3));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 16'h1473, 0, 0, 0, 3));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0, 16'h1473, 0, 0, 1, 2));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 16'h1473, 0, 0, 1, 2));
    tbl.push_back(mk(1, 4'hD, 0, 0, 0, 0, 0, 16'h1473, 1, 0, 1, 2));
    tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 0, 16'h1473, 0, 0, 1, 2));
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_attempts", attempts_left, MA);
    foreach (tbl[i]) begin
      cyc(1, tbl[i].kv, tbl[i].kc, tbl[i].cr, tbl[i].rv, tbl[i].rp);
      chk($sformatf("tbl%0d_dc", i), digit_count, tbl[i].dc);
      chk($sformatf("tbl%0d_cv", i), code_valid, tbl[i].cv);
      chk($sformatf("tbl%0d_code", i), code_out, tbl[i].code);
      chk($sformatf("tbl%0d_err", i), entry_error, tbl[i].err);
      chk($sformatf("tbl%0d_unl", i), unlocked, tbl[i].unl);
      chk($sformatf("tbl%0d_kr", i), key_ready, tbl[i].kr);
      chk($sformatf("tbl%0d_att", i), attempts_left, tbl[i].att);
    end
    cyc(1, 1, 4'h2, 0, 0, 0);
    cyc(1, 1, 4'hA, 0, 0, 0);
    submit(16'h9999);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 4'h5, 0, k == 2, 0);
      chk("stall_code", code_out, 16'h9999);
      chk("stall_cv", code_valid, 1);
      chk("stall_kr", key_ready, 0);
      chk("stall_att", attempts_left, 2);
    end
    cyc(1, 0, 0, 1, 0, 0);
    chk("hs_cv_drop", code_valid, 0);
    cyc(1, 0, 0, 0, 1, 1);
    chk("pass_unl", unlocked, 1);
    chk("pass_att", attempts_left, MA);
    for (int f = 0; f < 3; f++) begin
      fail_once();
      chk("fail_att", attempts_left, 2 - f);
    end
    chk("lock_enter", locked_out, 1);
    n = locked_out ? 1 : 0;
    for (int k = 0; k < 20 && locked_out; k++) begin
      cyc(1, 1, 4'h5, 0, 0, 0);
      if (locked_out) begin
        n++;
        chk("lock_kr", key_ready, 0);
      end
    end
    chk("lockout_len", n, L);
    chk("post_lock_kr", key_ready, 1);
    chk("post_lock_att", attempts_left, MA);
    chk("post_lock_dc", digit_count, 0);
    fail_once();
    submit(16'h5678);
    chk("pre_rst_send", code_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_send_cv", code_valid, 0);
    chk("rst_send_code", code_out, 0);
    chk("rst_send_kr", key_ready, 1);
    chk("rst_send_att", attempts_left, MA);
    for (int f = 0; f < 3; f++) fail_once();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pre_rst_lock", locked_out, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_lock_lo", locked_out, 0);
    chk("rst_lock_kr", key_ready, 1);
    chk("rst_lock_att", attempts_left, MA);
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
